// File: rtl/instr_seq_decoder_pkg.sv
// Package instr_seq_pkg: shared encodings for the instruction sequencer.
//   - opcode field values (ins[15:11])
//   - branch condition codes (ins[10:8] of Bcc)
//   - ALU operation codes driven on alu_op
//   - FSM state enumeration
package instr_seq_pkg;

    localparam logic [4:0] OP_LHI = 5'b00001;
    localparam logic [4:0] OP_LLI = 5'b00010;
    localparam logic [4:0] OP_LDR = 5'b00011;
    localparam logic [4:0] OP_STR = 5'b00101;
    localparam logic [4:0] OP_ALU = 5'b00110;
    localparam logic [4:0] OP_BCC = 5'b11000;
    localparam logic [4:0] OP_SYS = 5'b11100;  // NOP when ins[0]=0, HLT when ins[0]=1

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_Z  = 3'b001;
    localparam logic [2:0] COND_NZ = 3'b010;
    localparam logic [2:0] COND_N  = 3'b011;
    localparam logic [2:0] COND_C  = 3'b100;
    localparam logic [2:0] COND_V  = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_LHI = 2'b10;
    localparam logic [1:0] ALU_LLI = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

endpackage

// File: rtl/instr_seq_decoder_if.sv
// Interface instr_seq_if: all sequencer I/O except clk/rst.
//   master modport: the sequencer (control inputs, flags, PC, ext load in;
//                   ALU/RF/PC/memory controls and status out)
//   slave modport : the surrounding datapath / program loader
interface instr_seq_if #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 8,
    parameter int RF_AW  = 3
);
    logic              start;
    logic              step;
    logic [15:0]       instr_i;
    logic              alu_n, alu_z, alu_c, alu_v;
    logic [DATA_W-1:0] alu_o;
    logic [DATA_W-1:0] rf_b;
    logic [MEM_AW-1:0] pc_addr;
    logic              ext_mem_wen;
    logic [MEM_AW-1:0] ext_mem_addr;
    logic [DATA_W-1:0] ext_mem_data;

    logic [1:0]        alu_op;
    logic              alu_imm_sel;
    logic [DATA_W-1:0] alu_imm;
    logic              rf_wen;
    logic [RF_AW-1:0]  rf_waddr, rf_raddr_a, rf_raddr_b;
    logic              pc_en, pc_jump;
    logic [MEM_AW-1:0] pc_off;
    logic              mem_wen, mem_ren;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy, done, illegal;
    logic [15:0]       ins;

    modport master (
        input  start, step, instr_i, alu_n, alu_z, alu_c, alu_v, alu_o, rf_b,
               pc_addr, ext_mem_wen, ext_mem_addr, ext_mem_data,
        output alu_op, alu_imm_sel, alu_imm, rf_wen, rf_waddr, rf_raddr_a,
               rf_raddr_b, pc_en, pc_jump, pc_off, mem_wen, mem_ren, mem_addr,
               mem_wdata, busy, done, illegal, ins
    );

    modport slave (
        output start, step, instr_i, alu_n, alu_z, alu_c, alu_v, alu_o, rf_b,
               pc_addr, ext_mem_wen, ext_mem_addr, ext_mem_data,
        input  alu_op, alu_imm_sel, alu_imm, rf_wen, rf_waddr, rf_raddr_a,
               rf_raddr_b, pc_en, pc_jump, pc_off, mem_wen, mem_ren, mem_addr,
               mem_wdata, busy, done, illegal, ins
    );

endinterface

// File: rtl/instr_seq_decoder_cond.sv
// instr_seq_cond: combinational branch-condition evaluation.
//   cond_i          3-bit Bcc condition code
//   n_i/z_i/c_i/v_i ALU flags of the current EXEC result
//   taken_o         1 when the branch is taken (codes above 101 never taken)
module instr_seq_cond
    import instr_seq_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic       n_i,
    input  logic       z_i,
    input  logic       c_i,
    input  logic       v_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_AL: taken_o = 1'b1;
            COND_Z:  taken_o = z_i;
            COND_NZ: taken_o = ~z_i;
            COND_N:  taken_o = n_i;
            COND_C:  taken_o = c_i;
            COND_V:  taken_o = v_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_seq_decoder.sv
// instr_seq_decoder: multi-cycle fetch/decode/execute sequencer.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  instr_seq_if.master: start/step, instruction word, ALU flags/result,
//        store data, PC, external program-load path in; ALU/RF/PC/data-memory
//        controls, status (busy/done/illegal) and latched instruction out.
// Optional build macro ID_SINGLE_STEP_EN: each FETCH waits for one registered
// rising edge on step; without it step is ignored.
module instr_seq_decoder
    import instr_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 8,
    parameter int RF_AW  = 3
) (
    input logic         clk,
    input logic         rst,
    instr_seq_if.master bus
);

    state_e      state_q, state_d;
    logic [15:0] ins_q, ins_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        fetch_go;
    logic        taken;
    logic        legal;

    logic [4:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [7:0]  imm8;
    logic [4:0]  imm5;

    assign op   = ins_q[15:11];
    assign rd   = ins_q[10:8];
    assign ra   = ins_q[7:5];
    assign rb   = ins_q[4:2];
    assign imm8 = ins_q[7:0];
    assign imm5 = ins_q[4:0];

    assign legal = op inside {OP_LHI, OP_LLI, OP_LDR, OP_STR, OP_ALU, OP_BCC, OP_SYS};

    // Only the low MEM_AW bits of alu_o form the data address.
    logic unused_alu_bits;
    assign unused_alu_bits = ^bus.alu_o;

    instr_seq_cond u_cond (
        .cond_i  (rd),
        .n_i     (bus.alu_n),
        .z_i     (bus.alu_z),
        .c_i     (bus.alu_c),
        .v_i     (bus.alu_v),
        .taken_o (taken)
    );

`ifdef ID_SINGLE_STEP_EN
    // step is synchronised through two flops; a rising edge arms one fetch,
    // so a pulse arriving before FETCH is not lost.
    logic step_q, step_qq, pend_q, pend_d;

    assign pend_d   = (pend_q & ~(state_q == S_FETCH)) | (step_q & ~step_qq);
    assign fetch_go = pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= 1'b0;
            step_qq <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            step_q  <= bus.step;
            step_qq <= step_q;
            pend_q  <= pend_d;
        end
    end
`else
    logic unused_step;
    assign unused_step = bus.step;
    assign fetch_go    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ins_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ins_q     <= ins_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.ins     = ins_q;

    always_comb begin
        state_d         = state_q;
        ins_d           = ins_q;
        done_d          = done_q;
        illegal_d       = illegal_q;
        bus.alu_op      = ALU_ADD;
        bus.alu_imm_sel = 1'b0;
        bus.alu_imm     = '0;
        bus.rf_wen      = 1'b0;
        bus.rf_waddr    = '0;
        bus.rf_raddr_a  = '0;
        bus.rf_raddr_b  = '0;
        bus.pc_en       = 1'b0;
        bus.pc_jump     = 1'b0;
        bus.pc_off      = '0;
        bus.mem_wen     = 1'b0;
        bus.mem_ren     = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.busy        = 1'b1;

        // Decoded datapath controls stay stable from DECODE through WB.
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            bus.rf_raddr_a = RF_AW'(ra);
            bus.rf_raddr_b = RF_AW'(rb);
            bus.rf_waddr   = RF_AW'(rd);
            case (op)
                OP_LHI: begin
                    bus.alu_op      = ALU_LHI;
                    bus.alu_imm_sel = 1'b1;
                    bus.alu_imm     = DATA_W'(imm8);
                end
                OP_LLI: begin
                    bus.alu_op      = ALU_LLI;
                    bus.alu_imm_sel = 1'b1;
                    bus.alu_imm     = DATA_W'(imm8);
                end
                OP_LDR, OP_STR: begin
                    bus.alu_op      = ALU_ADD;
                    bus.alu_imm_sel = 1'b1;
                    bus.alu_imm     = DATA_W'($signed(imm5));
                end
                OP_ALU:  bus.alu_op = ins_q[0] ? ALU_SUB : ALU_ADD;
                OP_BCC:  bus.pc_off = MEM_AW'($signed(imm8));
                default: ;
            endcase
        end

        unique case (state_q)
            S_IDLE, S_HALT: begin
                bus.busy      = 1'b0;
                bus.mem_wen   = bus.ext_mem_wen;
                bus.mem_addr  = bus.ext_mem_addr;
                bus.mem_wdata = bus.ext_mem_data;
                if (bus.start) begin
                    state_d   = S_FETCH;
                    done_d    = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (fetch_go) begin
                    ins_d   = bus.instr_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_LHI, OP_LLI, OP_ALU: state_d = S_WB;
                    OP_LDR, OP_STR:         state_d = S_MEM;
                    OP_BCC: begin
                        bus.pc_en   = 1'b1;
                        bus.pc_jump = taken;
                        state_d     = S_FETCH;
                    end
                    OP_SYS: begin
                        if (ins_q[0]) begin
                            done_d  = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            bus.pc_en = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                bus.mem_addr = bus.alu_o[MEM_AW-1:0];
                if (op == OP_LDR) begin
                    bus.mem_ren = 1'b1;
                    state_d     = S_WB;
                end else begin
                    bus.mem_wen   = 1'b1;
                    bus.mem_wdata = bus.rf_b;
                    bus.pc_en     = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_WB: begin
                bus.rf_wen = 1'b1;
                bus.pc_en  = 1'b1;
                state_d    = S_FETCH;
            end
        endcase

        // A reset cycle aborts the instruction: no strobe may escape.
        if (rst) begin
            bus.rf_wen  = 1'b0;
            bus.pc_en   = 1'b0;
            bus.pc_jump = 1'b0;
            bus.mem_wen = 1'b0;
            bus.mem_ren = 1'b0;
        end
    end

endmodule
